// File: rtl/ahb_keypad_fifo_if.sv
// AHB-lite slave port bundle for the keypad FIFO peripheral.
// The master modport drives the request side and the slave modport drives the response side.
interface ahb_keypad_fifo_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_keypad_fifo.sv
// Keypad matrix scanner with per-key debounce, an event FIFO and a zero-wait AHB-lite slave.
// Define KEYPAD_RELEASE_EVT_EN to queue release events as well as press events.
module ahb_keypad_fifo #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int DEB_SCANS  = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    ahb_keypad_fifo_if.slave  bus,
    output logic [ROWS-1:0]   row,
    input  logic [COLS-1:0]   col,
    output logic              key_irq
);
    localparam int NKEYS = ROWS * COLS;
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DW    = $clog2(SCAN_DIV);
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = PW + 1;
`ifdef KEYPAD_RELEASE_EVT_EN
    localparam bit REL_EVT = 1'b1;
`else
    localparam bit REL_EVT = 1'b0;
`endif

    logic                       started_q, started_d;
    logic [DW-1:0]              div_q, div_d;
    logic [RW-1:0]              row_idx_q, row_idx_d;
    logic [ROWS-1:0]            row_q, row_d;
    logic                       sample;
    logic [NKEYS-1:0]           stable_q, stable_d;
    logic [NKEYS-1:0][3:0]      cnt_q, cnt_d;
    logic                       acc, acc_press;
    logic [6:0]                 acc_key;
    logic [7:0]                 mem_q [FIFO_DEPTH];
    logic [PW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]              count_q, count_d;
    logic                       empty, full, push, push_ok, pop, ovf_set;
    logic                       ovf_q, ovf_d, irq_en_q, irq_en_d, key_irq_q, key_irq_d;
    logic                       dp_valid_q, dp_valid_d, dp_write_q, dp_write_d;
    logic [1:0]                 dp_addr_q, dp_addr_d;
    logic                       addr_ph, wr_ctrl;
    logic [31:0]                status, raw, hrdata;
    logic [127:0]               stable_ext;
    logic                       unused_bits;

    // Scan timing: the slot counter only starts one cycle after reset so row 0 gets a full slot.
    // NOTE: always_comb uses blocking '=' with defaults first so no latches form; state updates use '<=' in always_ff.
    always_comb begin
        started_d = 1'b1;
        div_d     = div_q;
        row_idx_d = row_idx_q;
        sample    = 1'b0;
        if (started_q) begin
            if (div_q == DW'(SCAN_DIV - 1)) begin
                sample    = 1'b1;
                div_d     = '0;
                row_idx_d = (row_idx_q == RW'(ROWS - 1)) ? '0 : row_idx_q + RW'(1);
            end else begin
                div_d = div_q + DW'(1);
            end
        end
        for (int r = 0; r < ROWS; r++) row_d[r] = (row_idx_d != RW'(r));
    end

    // Debounce the sampled row; only the lowest eligible column is accepted per sample.
    always_comb begin
        stable_d  = stable_q;
        cnt_d     = cnt_q;
        acc       = 1'b0;
        acc_press = 1'b0;
        acc_key   = '0;
        if (sample) begin
            for (int r = 0; r < ROWS; r++) begin
                if (row_idx_q == RW'(r)) begin
                    for (int c = 0; c < COLS; c++) begin
                        if (~col[c] == stable_q[r*COLS+c]) begin
                            cnt_d[r*COLS+c] = '0;
                        end else begin
                            cnt_d[r*COLS+c] = (cnt_q[r*COLS+c] >= 4'(DEB_SCANS)) ? 4'(DEB_SCANS)
                                                                                  : cnt_q[r*COLS+c] + 4'd1;
                            if (!acc && cnt_d[r*COLS+c] >= 4'(DEB_SCANS)) begin
                                acc                = 1'b1;
                                acc_press          = ~col[c];
                                acc_key            = 7'(r*COLS + c);
                                stable_d[r*COLS+c] = ~stable_q[r*COLS+c];
                                cnt_d[r*COLS+c]    = '0;
                            end
                        end
                    end
                end
            end
        end
    end

    // Bus data phase and FIFO bookkeeping.
    always_comb begin
        addr_ph    = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
        dp_valid_d = addr_ph;
        dp_write_d = addr_ph ? bus.HWRITE : dp_write_q;
        dp_addr_d  = addr_ph ? bus.HADDR[3:2] : dp_addr_q;
        empty      = (count_q == '0);
        full       = (count_q == CW'(FIFO_DEPTH));
        push       = acc & (acc_press | REL_EVT);
        pop        = dp_valid_q & ~dp_write_q & (dp_addr_q == 2'd0) & ~empty;
        push_ok    = push & (~full | pop);
        ovf_set    = push & full & ~pop;
        wr_ptr_d   = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d    = count_q;
        if (push_ok && !pop)      count_d = count_q + CW'(1);
        else if (!push_ok && pop) count_d = count_q - CW'(1);
        wr_ctrl    = dp_valid_q & dp_write_q & (dp_addr_q == 2'd2);
        irq_en_d   = wr_ctrl ? bus.HWDATA[0] : irq_en_q;
        ovf_d      = (ovf_q & ~(wr_ctrl & bus.HWDATA[1])) | ovf_set;
        key_irq_d  = irq_en_q & (~empty | ovf_q);
    end

    always_comb begin
        stable_ext   = 128'(stable_q);
        raw          = stable_ext[31:0];
        status       = '0;
        status[0]    = empty;
        status[1]    = full;
        status[2]    = ovf_q;
        status[14:8] = 7'(count_q);
        hrdata       = '0;
        if (dp_valid_q && !dp_write_q) begin
            case (dp_addr_q)
                2'd0:    hrdata = {24'b0, empty ? 8'h00 : mem_q[rd_ptr_q]};
                2'd1:    hrdata = status;
                2'd2:    hrdata = {31'b0, irq_en_q};
                default: hrdata = raw;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            started_q  <= 1'b0;
            div_q      <= '0;
            row_idx_q  <= '0;
            row_q      <= '1;
            stable_q   <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            irq_en_q   <= 1'b0;
            key_irq_q  <= 1'b0;
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_addr_q  <= '0;
        end else begin
            started_q  <= started_d;
            div_q      <= div_d;
            row_idx_q  <= row_idx_d;
            row_q      <= row_d;
            stable_q   <= stable_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            irq_en_q   <= irq_en_d;
            key_irq_q  <= key_irq_d;
            dp_valid_q <= dp_valid_d;
            dp_write_q <= dp_write_d;
            dp_addr_q  <= dp_addr_d;
        end
    end

    // NOTE: FIFO storage has no reset; count and pointers decide which entries are visible.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) mem_q[wr_ptr_q] <= {acc_press, acc_key};
    end

    assign row           = row_q;
    assign key_irq       = key_irq_q;
    assign bus.HRDATA    = hrdata;
    assign bus.HREADYOUT = 1'b1;
    assign bus.HRESP     = 1'b0;
    assign unused_bits   = ^{bus.HSIZE, bus.HPROT, bus.HADDR[31:4], bus.HADDR[1:0],
                             bus.HTRANS[0], bus.HWDATA[31:2]};
endmodule

// File: tb/tb_ahb_keypad_fifo.sv
// Directed bench for ahb_keypad_fifo: a key-matrix model drives col, reads are scored by a bus monitor.
// Expected DATA/STATUS values depend on whether KEYPAD_RELEASE_EVT_EN is defined.
module tb_ahb_keypad_fifo;
    localparam int SCAN = 32;   // 4 rows x SCAN_DIV 8

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        key_irq;
    logic [15:0] keys;
    logic        mon_dp;
    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    ahb_keypad_fifo_if bus ();

    ahb_keypad_fifo #(
        .ROWS(4), .COLS(4), .SCAN_DIV(8), .DEB_SCANS(2), .FIFO_DEPTH(2)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .row(row), .col(col), .key_irq(key_irq)
    );

    always #5 clk = ~clk;

    // Switch matrix: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        col = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !row[r]) col[c] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: tracks read data phases from the bus itself and scores HRDATA against the queue.
    always @(posedge clk)
        mon_dp <= rst ? 1'b0 : (bus.HSEL & bus.HTRANS[1] & bus.HREADY & ~bus.HWRITE);

    always @(negedge clk) begin
        if (mon_dp) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected_read: got 0x%08h with no expected value queued", bus.HRDATA);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check(e.name, bus.HRDATA, e.exp);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HWRITE = 1'b0;
    endtask

    task automatic ahb_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
        exp_t e;
        @(posedge clk); #1;
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HADDR  = addr;
        bus.HWRITE = 1'b0;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
        @(posedge clk); #1;
        bus_idle();
    endtask

    task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HADDR  = addr;
        bus.HWRITE = 1'b1;
        @(posedge clk); #1;
        bus_idle();
        bus.HWDATA = data;
    endtask

    initial begin
        rst        = 1'b1;
        keys       = '0;
        bus.HSIZE  = 3'b010;
        bus.HPROT  = 4'b0011;
        bus.HREADY = 1'b1;
        bus.HWDATA = '0;
        // A STATUS read is left pending across reset; it must never reach a data phase.
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HADDR  = 32'h4;
        bus.HWRITE = 1'b0;

        @(posedge clk); @(negedge clk);
        check("reset_row", 32'(row), 32'hF);
        check("reset_hrdata", bus.HRDATA, 32'h0);
        check("reset_hreadyout", 32'(bus.HREADYOUT), 32'h1);
        check("reset_hresp", 32'(bus.HRESP), 32'h0);
        check("reset_irq", 32'(key_irq), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus_idle();
        @(posedge clk); @(negedge clk);
        check("first_row", 32'(row), 32'hE);
        ahb_read(32'h4, 32'h0000_0001, "status_after_reset");
        ahb_read(32'h0, 32'h0000_0000, "data_empty_read");

        // Single key 9 (row 2, col 1).
        keys[9] = 1'b1;
        idle(4*SCAN);
        ahb_read(32'hC, 32'h0000_0200, "raw_key9");
        ahb_read(32'h4, 32'h0000_0100, "status_count1");
        ahb_read(32'h0, 32'h0000_0089, "data_key9_press");
        ahb_read(32'h4, 32'h0000_0001, "status_after_pop");

        // Key 5 bounces every scan and never settles.
        for (int i = 0; i < 10; i++) begin
            keys[5] = ~keys[5];
            idle(SCAN);
        end
        idle(SCAN);
        ahb_read(32'hC, 32'h0000_0200, "raw_bounce");
        ahb_read(32'h4, 32'h0000_0001, "status_bounce");

        // Keys 4 and 6 become eligible together: lower column first.
        keys[4] = 1'b1;
        keys[6] = 1'b1;
        idle(5*SCAN);
        ahb_read(32'hC, 32'h0000_0250, "raw_simul");
        ahb_read(32'h4, 32'h0000_0202, "status_simul_full");
        ahb_read(32'h0, 32'h0000_0084, "data_key4_first");
        ahb_read(32'h0, 32'h0000_0086, "data_key6_second");
        ahb_read(32'h4, 32'h0000_0001, "status_simul_drained");
        @(negedge clk);
        check("irq_disabled", 32'(key_irq), 32'h0);

        // Release key 9.
        keys[9] = 1'b0;
        idle(4*SCAN);
        ahb_read(32'hC, 32'h0000_0050, "raw_release9");
`ifdef KEYPAD_RELEASE_EVT_EN
        ahb_read(32'h4, 32'h0000_0100, "status_release9");
        ahb_read(32'h0, 32'h0000_0009, "data_release9");
`else
        ahb_read(32'h4, 32'h0000_0001, "status_release9");
        ahb_read(32'h0, 32'h0000_0000, "data_release9");
`endif

        // Release keys 4 and 6.
        keys[4] = 1'b0;
        keys[6] = 1'b0;
        idle(5*SCAN);
        ahb_read(32'hC, 32'h0000_0000, "raw_all_released");
`ifdef KEYPAD_RELEASE_EVT_EN
        ahb_read(32'h4, 32'h0000_0202, "status_release46");
        ahb_read(32'h0, 32'h0000_0004, "data_release4");
        ahb_read(32'h0, 32'h0000_0006, "data_release6");
`endif
        ahb_read(32'h4, 32'h0000_0001, "status_release_done");

        // Overflow: three presses into a two-entry FIFO.
        keys[0] = 1'b1;
        keys[1] = 1'b1;
        keys[2] = 1'b1;
        idle(6*SCAN);
        ahb_read(32'hC, 32'h0000_0007, "raw_ovf");
        ahb_read(32'h4, 32'h0000_0206, "status_ovf");
        @(negedge clk);
        check("irq_off_before_en", 32'(key_irq), 32'h0);
        ahb_write(32'h8, 32'h0000_0003);
        idle(2);
        @(negedge clk);
        check("irq_on_after_en", 32'(key_irq), 32'h1);
        ahb_read(32'h4, 32'h0000_0202, "status_ovf_cleared");
        ahb_read(32'h8, 32'h0000_0001, "ctrl_readback");
        ahb_read(32'h0, 32'h0000_0080, "data_key0");
        idle(2);
        @(negedge clk);
        check("irq_one_left", 32'(key_irq), 32'h1);
        ahb_read(32'h0, 32'h0000_0081, "data_key1");
        idle(2);
        @(negedge clk);
        check("irq_drained", 32'(key_irq), 32'h0);
        ahb_read(32'h4, 32'h0000_0001, "status_final");

        idle(3);
        check("sb_drain", 32'(sb_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
